// File: rtl/vga_pkg.sv
// Shared definitions for the VGA fade controller: FSM state encoding and a
// helper that extracts one colour channel from a packed RGB bus.
package vga_pkg;

    typedef enum logic [1:0] {
        BLACK    = 2'd0,
        FADE_IN  = 2'd1,
        ON       = 2'd2,
        FADE_OUT = 2'd3
    } fade_state_t;

    localparam int MAX_BUS_BITS = 48;

    // Channel idx 0 is the LSB channel (blue); R sits in the top slice.
    function automatic logic [15:0] ch_slice(input logic [MAX_BUS_BITS-1:0] bus,
                                             input int idx,
                                             input int ch_bits);
        logic [MAX_BUS_BITS-1:0] mask;
        mask = (MAX_BUS_BITS'(1) << ch_bits) - MAX_BUS_BITS'(1);
        return 16'((bus >> (idx * ch_bits)) & mask);
    endfunction

endpackage

// File: rtl/vga_scale_channel.sv
// Combinational brightness scale of one colour channel: y = (c * l) >> STEP_BITS.
module vga_scale_channel #(
    parameter int CH_BITS   = 3,
    parameter int STEP_BITS = 3
) (
    input  logic [CH_BITS-1:0]   c,
    input  logic [STEP_BITS:0]   l,
    output logic [CH_BITS-1:0]   y
);

    localparam int PROD_BITS = CH_BITS + STEP_BITS + 1;

    logic [PROD_BITS-1:0] prod;

    // Full level (2^STEP_BITS) shifts back to exactly c; level 0 gives 0.
    assign prod = PROD_BITS'(c) * PROD_BITS'(l);
    assign y    = CH_BITS'(prod >> STEP_BITS);

endmodule

// File: rtl/vga_fade_ctrl.sv
// VGA output gate: forces black in reset/blanking, fades RGB frame-by-frame
// under a mute request, and delays the syncs to match the registered pixel.
module vga_fade_ctrl #(
    parameter int CH_BITS         = 3,
    parameter int STEP_BITS       = 3,
    parameter int FRAMES_PER_STEP = 2,
    parameter bit VSYNC_POL       = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3*CH_BITS-1:0]   rgb,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic                   blank,
    input  logic                   mute,
    output logic [3*CH_BITS-1:0]   video,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   muted,
    output logic                   busy
);

    import vga_pkg::*;

    localparam int RGB_BITS  = 3 * CH_BITS;
    localparam int LEVELS    = 1 << STEP_BITS;
    localparam int FCNT_BITS = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [STEP_BITS:0]   L_MAX     = (STEP_BITS+1)'(LEVELS);
    localparam logic [STEP_BITS:0]   L_ONE     = (STEP_BITS+1)'(1);
    localparam logic [FCNT_BITS-1:0] FCNT_LAST = FCNT_BITS'(FRAMES_PER_STEP - 1);

    fade_state_t          state;
    logic [STEP_BITS:0]   level;
    logic [FCNT_BITS-1:0] fcnt;
    logic                 vs_prev;
    logic                 tick;
    logic                 step;
    logic [RGB_BITS-1:0]  scaled;

    assign tick = (vsync_i == VSYNC_POL) && (vs_prev != VSYNC_POL);
    assign step = tick && (fcnt == FCNT_LAST);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [CH_BITS-1:0] c;
        assign c = CH_BITS'(ch_slice(MAX_BUS_BITS'(rgb), i, CH_BITS));

        vga_scale_channel #(
            .CH_BITS   (CH_BITS),
            .STEP_BITS (STEP_BITS)
        ) u_scale (
            .c (c),
            .l (level),
            .y (scaled[i*CH_BITS +: CH_BITS])
        );
    end

    // NOTE: every register here uses <= so all of them see the same
    // pre-edge values of state/level/fcnt regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BLACK;
            level   <= '0;
            fcnt    <= '0;
            vs_prev <= VSYNC_POL;  // held-active vsync across reset gives no tick
            video   <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            muted   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            vs_prev <= vsync_i;
            hsync_o <= hsync_i;
            vsync_o <= vsync_i;
            video   <= blank ? '0 : scaled;

            case (state)
                BLACK: begin
                    if (tick && !mute) begin
                        state <= FADE_IN;
                        fcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                FADE_IN: begin
                    // Direction change beats a coincident step.
                    if (tick && mute) begin
                        state <= FADE_OUT;
                        fcnt  <= '0;
                    end else if (step) begin
                        fcnt  <= '0;
                        muted <= 1'b0;
                        if (level >= L_MAX - L_ONE) begin
                            level <= L_MAX;
                            state <= ON;
                            busy  <= 1'b0;
                        end else begin
                            level <= level + L_ONE;
                        end
                    end else if (tick) begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                ON: begin
                    if (tick && mute) begin
                        state <= FADE_OUT;
                        fcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                FADE_OUT: begin
                    if (tick && !mute) begin
                        state <= FADE_IN;
                        fcnt  <= '0;
                    end else if (step) begin
                        fcnt <= '0;
                        if (level <= L_ONE) begin
                            level <= '0;
                            state <= BLACK;
                            busy  <= 1'b0;
                            muted <= 1'b1;
                        end else begin
                            level <= level - L_ONE;
                        end
                    end else if (tick) begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
